// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: stage occupancy encoding and default widths.
// Occupancy codes double as the entry count driven on occ_o.
package pipe_stage_skid_pkg;

    localparam int PIPE_DATA_W  = 64;
    localparam int FLUSH_CNT_W  = 8;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones once reached.
module sat_counter
    import pipe_stage_skid_pkg::*;
#(
    parameter int W = FLUSH_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    // count up on inc_i, stop at the maximum value
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with stall hold, flush kill and
// a saturating count of flushes that discarded live entries.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [7:0]        flush_cnt_o
);

    logic [1:0]        state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              kill;

    assign in_ready_o  = rst_n_i & (state_q != ST_FULL) & ~stall_i;
    assign out_valid_o = rst_n_i & (state_q != ST_EMPTY);
    assign out_data_o  = out_valid_o ? main_q : BUBBLE;
    assign occ_o       = rst_n_i ? state_q : ST_EMPTY;

    // a stalled stage never hands an entry downstream
    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i & ~stall_i;
    assign kill     = rst_n_i & flush_i & (state_q != ST_EMPTY);

    // occupancy and payload update; flush beats stall beats transfers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else if (!stall_i) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= in_data_i;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    unique case ({in_xfer, out_xfer})
                        2'b11: main_q <= in_data_i;
                        2'b10: begin
                            skid_q  <= in_data_i;
                            state_q <= ST_FULL;
                        end
                        2'b01: begin
                            main_q  <= BUBBLE;
                            state_q <= ST_EMPTY;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                        state_q <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    sat_counter #(
        .W(FLUSH_CNT_W)
    ) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (kill),
        .cnt_o  (flush_cnt_o)
    );

endmodule
